// File: rtl/lc3_br_ctrl.sv
// LC-3 BR sequencer: issues ld_ben, samples ben the following cycle, and on a taken
// branch loads PC with pc + SEXT(offset). Optional statistics counters behind LC3_BR_STATS_EN.
module lc3_br_ctrl #(
  parameter int DATA_W = 16,
  parameter int OFF_W  = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] ir,
  input  logic [DATA_W-1:0] pc,
  input  logic              ben,
  output logic              ld_ben,
  output logic              ld_pc,
  output logic [DATA_W-1:0] pc_next,
  output logic              busy,
  output logic              done,
  output logic              taken,
  output logic              illegal
`ifdef LC3_BR_STATS_EN
  ,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  ntkn_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, S_BEN, S_EVAL} state_t;

  state_t            state, state_n;
  logic [OFF_W-1:0]  off_q;
  logic [DATA_W-1:0] pc_q;
  logic              ill_q;
  logic              is_br, accept, eval_ok;
  logic [DATA_W-1:0] off_ext;

  // Only the opcode and offset fields of ir matter here; CNT_W is only consumed by the stats build.
  logic unused_ok;
  assign unused_ok = &{1'b0, ir[DATA_W-5:OFF_W], CNT_W[0]};

  assign is_br  = (ir[DATA_W-1:DATA_W-4] == 4'b0000);
  assign accept = (state == IDLE) && start && is_br;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      off_q <= '0;
      pc_q  <= '0;
      ill_q <= 1'b0;
    end else begin
      state <= state_n;
      ill_q <= (state == IDLE) && start && !is_br;
      if (accept) begin
        off_q <= ir[OFF_W-1:0];
        pc_q  <= pc;
      end
    end
  end

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    ld_ben  = 1'b0;
    case (state)
      IDLE:    if (accept) state_n = S_BEN;
      S_BEN: begin
        busy    = 1'b1;
        ld_ben  = 1'b1;
        state_n = S_EVAL;
      end
      S_EVAL: begin
        busy    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // ben is the NZP block's registered result, so completion is decided in the S_EVAL cycle itself.
  // A reset arriving in that cycle suppresses completion so the aborted request leaves no trace.
  assign eval_ok = (state == S_EVAL) && !rst;
  assign off_ext = {{(DATA_W-OFF_W){off_q[OFF_W-1]}}, off_q};
  assign ld_pc   = eval_ok && ben;
  assign taken   = ld_pc;
  assign illegal = ill_q && !rst;
  assign done    = eval_ok || illegal;
  assign pc_next = ld_pc ? (pc_q + off_ext) : '0;

`ifdef LC3_BR_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      taken_cnt <= '0;
      ntkn_cnt  <= '0;
    end else begin
      if (done && taken && (taken_cnt != '1))
        taken_cnt <= taken_cnt + 1'b1;
      if (done && !taken && !illegal && (ntkn_cnt != '1))
        ntkn_cnt <= ntkn_cnt + 1'b1;
    end
  end
`endif

endmodule
